// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs one fetch at a time against a slow instruction memory,
// and buffers returned words in a small FIFO toward decode with valid/ready and redirect support.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 6,
    parameter int          FIFO_DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_valid,
    output logic [31:0] fetch_instruction,
    output logic [31:0] fetch_pc,
    input  logic        fetch_ready,
    output logic        misaligned_error
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(MEM_LATENCY);

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [31:0]      PC_STEP    = 32'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_WAIT, ST_CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d, count_after_pop;
    logic [31:0]      buf_instr_q [FIFO_DEPTH];
    logic [31:0]      buf_instr_d [FIFO_DEPTH];
    logic [31:0]      buf_pc_q    [FIFO_DEPTH];
    logic [31:0]      buf_pc_d    [FIFO_DEPTH];
    logic [31:0]      head_instr_q, head_instr_d, head_pc_q, head_pc_d;
    logic             valid_q, valid_d, misaligned_q, misaligned_d;
    logic             push, pop;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        buf_instr_d     = buf_instr_q;
        buf_pc_d        = buf_pc_q;
        head_instr_d    = head_instr_q;
        head_pc_d       = head_pc_q;
        valid_d         = valid_q;
        misaligned_d    = 1'b0;
        push            = 1'b0;
        pop             = valid_q && fetch_ready;
        count_after_pop = pop ? count_q - COUNT_ONE : count_q;

        if (redirect_valid) begin
            // Flush wins over any same-cycle capture or pop; the in-flight word is dropped.
            state_d      = ST_REQUEST;
            pc_d         = {redirect_target[31:2], 2'b00};
            misaligned_d = (redirect_target[1:0] != 2'b00);
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            valid_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQUEST;
                ST_REQUEST: begin
                    addr_d = pc_q;
                    cnt_d  = CNT_INIT;
                    // Reserve a slot now so the capture can never overflow.
                    if (count_after_pop < COUNT_FULL) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    push    = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = ST_REQUEST;
                end
                default: state_d = ST_IDLE;
            endcase

            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_instruction;
                buf_pc_d[wr_ptr_q]    = addr_q;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = push ? count_after_pop + COUNT_ONE : count_after_pop;
            valid_d = (count_d != '0);
            // Head is registered so the outputs hold their last value once the buffer drains.
            if (count_d != '0) begin
                head_instr_d = buf_instr_d[rd_ptr_d];
                head_pc_d    = buf_pc_d[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

    assign imem_address      = addr_q;
    assign fetch_valid       = valid_q;
    assign fetch_instruction = head_instr_q;
    assign fetch_pc          = head_pc_q;
    assign misaligned_error  = misaligned_q;
endmodule
